// File: rtl/maxnet_pkg.sv
// Shared types and FP32 constants for the Maxnet feeder slice.
// Import with: import maxnet_pkg::*;
package maxnet_pkg;

    localparam int N_INPUTS = 4;

    localparam logic [31:0] FP_ZERO           = 32'h0000_0000;
    localparam logic [31:0] FP_SIGN_BIT       = 32'h8000_0000;
    localparam logic [7:0]  FP_EXP_ALL1       = 8'hFF;
    localparam logic [31:0] EPS_RESET_DEFAULT = 32'h3E00_0000;  // 0.125

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/maxnet_feeder_fp_sanitize.sv
// Combinational FP32 sanitiser feeding the operand bank.
// With MAXNET_FEEDER_CLAMP_EN defined, negatives (incl. -0) and NaNs become +0; otherwise bit-exact.
import maxnet_pkg::*;

module fp_sanitize (
    input  logic [31:0] din,
    output logic [31:0] dout
);

`ifdef MAXNET_FEEDER_CLAMP_EN
    logic is_neg;
    logic is_nan;

    assign is_neg = |(din & FP_SIGN_BIT);
    assign is_nan = (din[30:23] == FP_EXP_ALL1) && (din[22:0] != 23'd0);
    // +Inf has a zero mantissa, so it is not a NaN and passes through.
    assign dout   = (is_neg || is_nan) ? FP_ZERO : din;
`else
    assign dout = din;
`endif

endmodule

// File: rtl/maxnet_feeder.sv
// Upstream feeder for Maxnet: buffers four FP32 operands, runs one Maxnet pass, returns max + run length.
// Optional input clamping is enabled by defining MAXNET_FEEDER_CLAMP_EN.
import maxnet_pkg::*;

module maxnet_feeder #(
    parameter logic [31:0] EPS_RESET = EPS_RESET_DEFAULT,
    parameter int          CYC_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             eps_we,
    input  logic [31:0]      eps_data,
    output logic             mx_start,
    output logic [31:0]      mx_epsilon,
    output logic [31:0]      mx_num1,
    output logic [31:0]      mx_num2,
    output logic [31:0]      mx_num3,
    output logic [31:0]      mx_num4,
    input  logic             mx_done,
    input  logic [31:0]      mx_max,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_max,
    output logic [CYC_W-1:0] res_cycles
);

    localparam logic [1:0]       CNT_LAST = 2'(N_INPUTS - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

    state_e           state;
    logic [1:0]       cnt;
    logic [31:0]      num_q [N_INPUTS];
    logic [31:0]      eps_q;
    logic             start_q;
    logic [31:0]      res_max_q;
    logic [CYC_W-1:0] res_cycles_q;
    logic [31:0]      clean;

    fp_sanitize u_sanitize (
        .din  (in_data),
        .dout (clean)
    );

    // Handshake flags decode registered state only, so no input reaches them combinationally.
    assign in_ready   = (state == FILL);
    assign res_valid  = (state == OUT);
    assign mx_start   = start_q;
    assign mx_epsilon = eps_q;
    assign mx_num1    = num_q[0];
    assign mx_num2    = num_q[1];
    assign mx_num3    = num_q[2];
    assign mx_num4    = num_q[3];
    assign res_max    = res_max_q;
    assign res_cycles = res_cycles_q;

    // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            cnt          <= 2'd0;
            eps_q        <= EPS_RESET;
            start_q      <= 1'b0;
            res_max_q    <= FP_ZERO;
            res_cycles_q <= '0;
            // NOTE: the operand bank is reset because Maxnet sees it directly on mx_num1..4.
            for (int i = 0; i < N_INPUTS; i++) begin
                num_q[i] <= FP_ZERO;
            end
        end else begin
            start_q <= 1'b0;

            case (state)
                FILL: begin
                    if (in_valid) begin
                        num_q[cnt] <= clean;
                        cnt        <= cnt + 2'd1;
                        if (cnt == CNT_LAST) begin
                            state   <= START;
                            start_q <= 1'b1;
                        end
                    end
                end
                START: begin
                    res_cycles_q <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (mx_done) begin
                        res_max_q <= mx_max;
                        state     <= OUT;
                    end else if (res_cycles_q != '1) begin
                        res_cycles_q <= res_cycles_q + CYC_ONE;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase

            // Epsilon is frozen while a run is in flight.
            if (eps_we && (state == FILL || state == OUT)) begin
                eps_q <= eps_data;
            end
        end
    end

endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed self-checking bench for maxnet_feeder; expectations are hand-computed constants.
// Clamp expectations follow MAXNET_FEEDER_CLAMP_EN.
module tb_maxnet_feeder;

    localparam logic [31:0] EPS_RST = 32'h3E00_0000;
    localparam logic [31:0] EPS_NEW = 32'h3D4C_CCCD;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        eps_we;
    logic [31:0] eps_data;
    logic        mx_start;
    logic [31:0] mx_epsilon;
    logic [31:0] mx_num1, mx_num2, mx_num3, mx_num4;
    logic        mx_done;
    logic [31:0] mx_max;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_max;
    logic [15:0] res_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    maxnet_feeder #(
        .EPS_RESET (EPS_RST),
        .CYC_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .eps_we     (eps_we),
        .eps_data   (eps_data),
        .mx_start   (mx_start),
        .mx_epsilon (mx_epsilon),
        .mx_num1    (mx_num1),
        .mx_num2    (mx_num2),
        .mx_num3    (mx_num3),
        .mx_num4    (mx_num4),
        .mx_done    (mx_done),
        .mx_max     (mx_max),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_max    (res_max),
        .res_cycles (res_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0][31:0] mk(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        logic [3:0][31:0] w;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        return w;
    endfunction

    task automatic check_reset();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mx_start", {31'd0, mx_start}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_max", res_max, 32'd0);
        check("rst_res_cycles", {16'd0, res_cycles}, 32'd0);
        check("rst_eps", mx_epsilon, EPS_RST);
        check("rst_num1", mx_num1, 32'd0);
        check("rst_num2", mx_num2, 32'd0);
        check("rst_num3", mx_num3, 32'd0);
        check("rst_num4", mx_num4, 32'd0);
    endtask

    // Streams four words; pattern bit k gives in_valid on cycle k, then valid stays high.
    task automatic feed(input logic [3:0][31:0] words, input logic [6:0] pattern, input int plen);
        int idx = 0;
        int k   = 0;
        while (idx < 4 && k < 64) begin
            in_valid = (k < plen) ? pattern[k] : 1'b1;
            in_data  = words[idx];
            if (in_valid && in_ready) idx++;
            k++;
            step();
        end
        in_valid = 1'b0;
        check("feed_accepted", idx, 32'd4);
        check("start_pulse", {31'd0, mx_start}, 32'd1);
        check("in_ready_start", {31'd0, in_ready}, 32'd0);
    endtask

    // Entered in the START cycle; holds done low for n_wait WAIT cycles, then pulses it.
    task automatic run_wait(input logic [3:0][31:0] ops, input int n_wait, input logic [31:0] maxv,
                            input logic [31:0] cyc_exp, input bit eps_poke, input logic [31:0] eps_exp);
        check("num1", mx_num1, ops[0]);
        check("num2", mx_num2, ops[1]);
        check("num3", mx_num3, ops[2]);
        check("num4", mx_num4, ops[3]);
        step();
        check("start_one_cycle", {31'd0, mx_start}, 32'd0);
        check("in_ready_wait", {31'd0, in_ready}, 32'd0);
        check("res_valid_wait", {31'd0, res_valid}, 32'd0);
        for (int i = 0; i < n_wait; i++) begin
            eps_we   = eps_poke && (i == 0);
            eps_data = EPS_NEW;
            step();
        end
        eps_we = 1'b0;
        check("eps_during_run", mx_epsilon, eps_exp);
        mx_done = 1'b1;
        mx_max  = maxv;
        step();
        mx_done = 1'b0;
        mx_max  = 32'hDEAD_BEEF;
        check("res_valid_out", {31'd0, res_valid}, 32'd1);
        check("res_max", res_max, maxv);
        check("res_cycles", {16'd0, res_cycles}, cyc_exp);
        check("num1_stable", mx_num1, ops[0]);
        check("num4_stable", mx_num4, ops[3]);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("drain_res_valid", {31'd0, res_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [3:0][31:0] w;
        logic [3:0][31:0] w_exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        eps_we    = 1'b0;
        eps_data  = 32'd0;
        mx_done   = 1'b0;
        mx_max    = 32'd0;
        res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset();

        // Basic back-to-back run, five WAIT cycles before done.
        w = mk(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        feed(w, 7'b0, 0);
        run_wait(w, 5, 32'h3E99_999A, 32'd5, 1'b0, EPS_RST);
        drain();

        // Gapped input: valid 1,0,0,1,0,1,1.
        w = mk(32'h3F00_0000, 32'h3F40_0000, 32'h3FC0_0000, 32'h40A0_0000);
        feed(w, 7'b1101001, 7);
        run_wait(w, 3, 32'h40A0_0000, 32'd3, 1'b0, EPS_RST);

        // Backpressure in OUT with a pending input word.
        in_valid  = 1'b1;
        in_data   = 32'h4120_0000;
        res_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_res_max", res_max, 32'h40A0_0000);
            check("bp_res_cycles", {16'd0, res_cycles}, 32'd3);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_num1", mx_num1, 32'h3F00_0000);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_release_valid", {31'd0, res_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_no_early_accept", mx_num1, 32'h3F00_0000);

        // Epsilon write during WAIT is ignored; during FILL it lands.
        w = mk(32'h4120_0000, 32'h3F80_0000, 32'h4100_0000, 32'h4040_0000);
        feed(w, 7'b0, 0);
        run_wait(w, 4, 32'h4120_0000, 32'd4, 1'b1, EPS_RST);
        drain();
        eps_we   = 1'b1;
        eps_data = EPS_NEW;
        step();
        eps_we = 1'b0;
        check("eps_fill_write", mx_epsilon, EPS_NEW);

        // Clamp vectors.
        w = mk(32'hBF80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h7F80_0000);
`ifdef MAXNET_FEEDER_CLAMP_EN
        w_exp = mk(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000);
`else
        w_exp = w;
`endif
        feed(w, 7'b0, 0);
        run_wait(w_exp, 1, 32'h7F80_0000, 32'd1, 1'b0, EPS_NEW);
        drain();

        // Reset in the middle of WAIT, then a stray done.
        w = mk(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        feed(w, 7'b0, 0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset();
        mx_done = 1'b1;
        mx_max  = 32'h1234_5678;
        step();
        mx_done = 1'b0;
        check("stray_done_valid", {31'd0, res_valid}, 32'd0);
        check("stray_done_ready", {31'd0, in_ready}, 32'd1);
        check("stray_done_max", res_max, 32'd0);
        feed(w, 7'b0, 0);
        run_wait(w, 2, 32'h4080_0000, 32'd2, 1'b0, EPS_RST);
        drain();

        // Saturation of the run-length counter.
        feed(w, 7'b0, 0);
        run_wait(w, 70000, 32'h4200_0000, 32'h0000_FFFF, 1'b0, EPS_RST);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
